// File: rtl/bp_pkg.sv
// Shared types for the branch resolution controller: FSM state encoding,
// queue entry layout and a saturating counter helper.
package bp_pkg;

    // Widest PC the queue entry can carry; the controller's AW must not exceed it.
    localparam int unsigned BP_PC_W_MAX = 32;

    // Width of the mispredict statistics counter.
    localparam int unsigned BP_CNT_W = 16;

    // Controller states: normal issue tracking, or holding the pipeline flush.
    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } bp_state_e;

    // One in-flight branch: predicted direction and the PC to use if it is wrong.
    typedef struct packed {
        logic                   pred;
        logic [BP_PC_W_MAX-1:0] alt_pc;
    } bp_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [BP_CNT_W-1:0] sat_inc(input logic [BP_CNT_W-1:0] val);
        logic [BP_CNT_W-1:0] res;
        if (val == {BP_CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + BP_CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_fifo.sv
// In-flight branch queue: power-of-two FIFO with synchronous clear.
// A push while full is accepted only when a pop happens in the same cycle,
// so a full queue can be refilled as its head retires.
module branch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          empty_s;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop against occupancy; clear overrides both.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        empty_s   = (count_r == CW'(0));
        do_pop_s  = pop_i & ~empty_s & ~clear_i;
        do_push_s = push_i & ~clear_i & (~full_s | do_pop_s);
    end

    // Entry storage; written at the tail on every accepted push.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata_o = mem_r[rd_ptr_r];
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = count_r;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller. Tracks predicted branches from ID in order,
// compares each against its EX outcome, trains the predictor, and on a
// mispredict squashes all younger branches and holds a fetch redirect.
module branch_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned AW             = 32,
    parameter int unsigned RECOVER_CYCLES = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          br_valid_i,
    input  logic          predict_i,
    input  logic [AW-1:0] alt_pc_i,
    input  logic          res_valid_i,
    input  logic          res_taken_i,
    output logic          update_o,
    output logic          result_o,
    output logic          stall_o,
    output logic          flush_o,
    output logic [AW-1:0] redirect_pc_o,
    output logic [15:0]   mispred_cnt_o,
    output logic          err_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = 3;

    bp_state_e             state_r;
    logic [TW-1:0]         timer_r;
    logic                  flush_r;
    logic [AW-1:0]         redirect_r;
    logic                  update_r;
    logic                  result_r;
    logic [BP_CNT_W-1:0]   mispred_cnt_r;
    logic                  err_r;

    bp_entry_t             wr_entry_s;
    bp_entry_t             head_s;
    logic                  full_s;
    logic                  empty_s;
    logic [CW-1:0]         count_s;
    logic                  normal_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  mispred_s;
    logic                  stall_s;
    logic                  empty_err_s;

    // Pack the incoming branch into a queue entry.
    always_comb begin
        wr_entry_s        = '0;
        wr_entry_s.pred   = predict_i;
        wr_entry_s.alt_pc = BP_PC_W_MAX'(alt_pc_i);
    end

    // Resolution, mispredict detection and enqueue qualification. A mispredict
    // blocks the enqueue because the new branch is younger and gets squashed.
    always_comb begin
        normal_s    = (state_r == ST_NORMAL);
        pop_s       = res_valid_i & ~empty_s;
        mispred_s   = pop_s & (head_s.pred != res_taken_i);
        push_s      = br_valid_i & normal_s & ~mispred_s & (~full_s | pop_s);
        stall_s     = br_valid_i & normal_s & full_s;
        empty_err_s = res_valid_i & empty_s & normal_s;
    end

    branch_fifo #(
        .DEPTH (DEPTH),
        .DW    ($bits(bp_entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (mispred_s),
        .push_i  (push_s),
        .wdata_i (wr_entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Recovery FSM: latch the redirect on a mispredict and hold flush for the
    // configured number of cycles before accepting branches again.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_NORMAL;
            timer_r    <= '0;
            flush_r    <= 1'b0;
            redirect_r <= '0;
        end else begin
            case (state_r)
                ST_NORMAL: begin
                    if (mispred_s) begin
                        state_r    <= ST_RECOVER;
                        flush_r    <= 1'b1;
                        redirect_r <= head_s.alt_pc[AW-1:0];
                        timer_r    <= TW'(RECOVER_CYCLES - 1);
                    end
                end
                ST_RECOVER: begin
                    if (timer_r == TW'(0)) begin
                        state_r <= ST_NORMAL;
                        flush_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - TW'(1);
                    end
                end
                default: begin
                    state_r <= ST_NORMAL;
                    flush_r <= 1'b0;
                    timer_r <= '0;
                end
            endcase
        end
    end

    // Predictor training strobe, one cycle after every retired branch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            update_r <= 1'b0;
            result_r <= 1'b0;
        end else begin
            update_r <= pop_s;
            if (pop_s) begin
                result_r <= res_taken_i;
            end
        end
    end

    // Mispredict statistics and sticky protocol error for resolves with no branch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mispred_cnt_r <= '0;
            err_r         <= 1'b0;
        end else begin
            if (mispred_s) begin
                mispred_cnt_r <= sat_inc(mispred_cnt_r);
            end
            if (empty_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign update_o      = update_r;
    assign result_o      = result_r;
    assign stall_o       = stall_s;
    assign flush_o       = flush_r;
    assign redirect_pc_o = redirect_r;
    assign mispred_cnt_o = mispred_cnt_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: one instance with a single-cycle
// flush and one with a three-cycle flush, driven from one linear sequence.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst_i;

    // instance A: RECOVER_CYCLES = 1
    logic        br, pred, rv, rt;
    logic [31:0] alt;
    logic        upd, res, stall, flush, err;
    logic [31:0] rpc;
    logic [15:0] mcnt;

    // instance B: RECOVER_CYCLES = 3
    logic        br3, pred3, rv3, rt3;
    logic [31:0] alt3;
    logic        upd3, res3, stall3, flush3, err3;
    logic [31:0] rpc3;
    logic [15:0] mcnt3;

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_ctrl #(.DEPTH(4), .AW(32), .RECOVER_CYCLES(1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .br_valid_i(br), .predict_i(pred), .alt_pc_i(alt),
        .res_valid_i(rv), .res_taken_i(rt),
        .update_o(upd), .result_o(res), .stall_o(stall), .flush_o(flush),
        .redirect_pc_o(rpc), .mispred_cnt_o(mcnt), .err_o(err)
    );

    branch_resolve_ctrl #(.DEPTH(4), .AW(32), .RECOVER_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst_i),
        .br_valid_i(br3), .predict_i(pred3), .alt_pc_i(alt3),
        .res_valid_i(rv3), .res_taken_i(rt3),
        .update_o(upd3), .result_o(res3), .stall_o(stall3), .flush_o(flush3),
        .redirect_pc_o(rpc3), .mispred_cnt_o(mcnt3), .err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        br = 1'b0; pred = 1'b0; alt = 32'h0; rv = 1'b0; rt = 1'b0;
        br3 = 1'b0; pred3 = 1'b0; alt3 = 32'h0; rv3 = 1'b0; rt3 = 1'b0;

        // reset state
        #3;
        chk("rst_update", {31'd0, upd}, 32'd0);
        chk("rst_result", {31'd0, res}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect", rpc, 32'h0);
        chk("rst_mcnt", {16'd0, mcnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        #9 rst_i = 1'b1;
        tick();

        // correct taken prediction
        br = 1'b1; pred = 1'b1; alt = 32'h100;
        #1 chk("t1_stall", {31'd0, stall}, 32'd0);
        tick();
        br = 1'b0; rv = 1'b1; rt = 1'b1;
        tick();
        rv = 1'b0;
        chk("t1_update", {31'd0, upd}, 32'd1);
        chk("t1_result", {31'd0, res}, 32'd1);
        chk("t1_flush", {31'd0, flush}, 32'd0);
        chk("t1_mcnt", {16'd0, mcnt}, 32'd0);
        chk("t1_count", {29'd0, dut.u_fifo.count_o}, 32'd0);
        tick();
        chk("t1_update_pulse", {31'd0, upd}, 32'd0);

        // mispredict: predicted taken, actually not taken
        br = 1'b1; pred = 1'b1; alt = 32'h204;
        tick();
        br = 1'b0; rv = 1'b1; rt = 1'b0;
        tick();
        rv = 1'b0;
        chk("t2_flush", {31'd0, flush}, 32'd1);
        chk("t2_redirect", rpc, 32'h204);
        chk("t2_update", {31'd0, upd}, 32'd1);
        chk("t2_result", {31'd0, res}, 32'd0);
        chk("t2_count", {29'd0, dut.u_fifo.count_o}, 32'd0);
        chk("t2_mcnt", {16'd0, mcnt}, 32'd1);
        tick();
        chk("t2_flush_end", {31'd0, flush}, 32'd0);
        chk("t2_update_end", {31'd0, upd}, 32'd0);

        // fill queue, then push while full with a correct resolution
        for (int i = 0; i < 4; i++) begin
            br = 1'b1; pred = 1'b0; alt = 32'h10 + 32'(i);
            tick();
        end
        chk("t3_count_full", {29'd0, dut.u_fifo.count_o}, 32'd4);
        br = 1'b1; pred = 1'b0; alt = 32'h14;
        #1 chk("t3_stall", {31'd0, stall}, 32'd1);
        rv = 1'b1; rt = 1'b0;
        #1 chk("t3_stall_pop", {31'd0, stall}, 32'd1);
        tick();
        br = 1'b0; rv = 1'b0;
        chk("t3_count_keep", {29'd0, dut.u_fifo.count_o}, 32'd4);
        chk("t3_update", {31'd0, upd}, 32'd1);
        chk("t3_flush", {31'd0, flush}, 32'd0);
        // retire 0x11 correctly, then mispredict on 0x12
        rv = 1'b1; rt = 1'b0;
        tick();
        rv = 1'b1; rt = 1'b1;
        tick();
        rv = 1'b0; br = 1'b1; pred = 1'b0; alt = 32'h55;
        #1;
        chk("t3_flush_mp", {31'd0, flush}, 32'd1);
        chk("t3_redirect", rpc, 32'h12);
        chk("t3_mcnt", {16'd0, mcnt}, 32'd2);
        chk("t3_count_clr", {29'd0, dut.u_fifo.count_o}, 32'd0);
        chk("t3_stall_recover", {31'd0, stall}, 32'd0);
        tick();
        br = 1'b0;
        chk("t3_br_ignored", {29'd0, dut.u_fifo.count_o}, 32'd0);
        chk("t3_flush_end", {31'd0, flush}, 32'd0);

        // resolve with empty queue in NORMAL
        rv = 1'b1; rt = 1'b1;
        tick();
        rv = 1'b0;
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_no_update", {31'd0, upd}, 32'd0);
        tick();
        chk("t4_err_sticky", {31'd0, err}, 32'd1);

        // three-cycle recovery with three queued entries
        br3 = 1'b1; pred3 = 1'b1; alt3 = 32'h300;
        tick();
        alt3 = 32'h304;
        tick();
        alt3 = 32'h308;
        tick();
        br3 = 1'b0;
        chk("t5_count3", {29'd0, dut3.u_fifo.count_o}, 32'd3);
        rv3 = 1'b1; rt3 = 1'b0;
        tick();
        br3 = 1'b1; pred3 = 1'b1; alt3 = 32'h3A0;
        #1;
        chk("t5_flush_c1", {31'd0, flush3}, 32'd1);
        chk("t5_redirect_c1", rpc3, 32'h300);
        chk("t5_mcnt", {16'd0, mcnt3}, 32'd1);
        chk("t5_count_clr", {29'd0, dut3.u_fifo.count_o}, 32'd0);
        chk("t5_stall_recover", {31'd0, stall3}, 32'd0);
        chk("t5_update", {31'd0, upd3}, 32'd1);
        tick();
        chk("t5_flush_c2", {31'd0, flush3}, 32'd1);
        chk("t5_redirect_c2", rpc3, 32'h300);
        chk("t5_br_ignored", {29'd0, dut3.u_fifo.count_o}, 32'd0);
        chk("t5_no_err_c2", {31'd0, err3}, 32'd0);
        tick();
        rv3 = 1'b0;
        chk("t5_flush_c3", {31'd0, flush3}, 32'd1);
        chk("t5_redirect_c3", rpc3, 32'h300);
        chk("t5_no_err_c3", {31'd0, err3}, 32'd0);
        tick();
        chk("t5_flush_done", {31'd0, flush3}, 32'd0);
        chk("t5_count_still0", {29'd0, dut3.u_fifo.count_o}, 32'd0);
        tick();
        br3 = 1'b0;
        chk("t5_enq_after", {29'd0, dut3.u_fifo.count_o}, 32'd1);

        // async reset in the middle of a flush
        rv3 = 1'b1; rt3 = 1'b0;
        tick();
        rv3 = 1'b0;
        chk("t6_flush_pre", {31'd0, flush3}, 32'd1);
        chk("t6_mcnt_pre", {16'd0, mcnt3}, 32'd2);
        #2 rst_i = 1'b0;
        #1;
        chk("t6_flush_rst", {31'd0, flush3}, 32'd0);
        chk("t6_count_rst", {29'd0, dut3.u_fifo.count_o}, 32'd0);
        chk("t6_mcnt_rst", {16'd0, mcnt3}, 32'd0);
        chk("t6_redirect_rst", rpc3, 32'h0);
        chk("t6_err_rst", {31'd0, err}, 32'd0);
        #1 rst_i = 1'b1;
        br3 = 1'b1; pred3 = 1'b0; alt3 = 32'h3B0;
        tick();
        br3 = 1'b0;
        chk("t6_enq_first", {29'd0, dut3.u_fifo.count_o}, 32'd1);
        chk("t6_flush_idle", {31'd0, flush3}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter DEPTH, 4, in-flight branch queue entries (power of two, 2..16).
REQ-002 Parameter AW, 32, PC width.
REQ-003 Parameter RECOVER_CYCLES, 1, flush hold length in cycles (1..7).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 br_valid_i  in  1  ID stage presents a conditional branch this cycle.
REQ-007 predict_i  in  1  predictor output for that branch (1 = taken).
REQ-008 alt_pc_i  in  AW  PC to use if the prediction is wrong (fall-through if predicted taken, target if not).
REQ-009 res_valid_i  in  1  EX stage resolves the oldest in-flight branch.
REQ-010 res_taken_i  in  1  actual outcome of that branch.
REQ-011 update_o  out  1  predictor update strobe.
REQ-012 result_o  out  1  outcome accompanying update_o.
REQ-013 stall_o  out  1  queue full; ID must hold the branch.
REQ-014 flush_o  out  1  squash younger instructions and redirect fetch.
REQ-015 redirect_pc_o  out  AW  fetch redirect PC, valid while flush_o=1.
REQ-016 mispred_cnt_o  out  16  saturating mispredict count.
REQ-017 err_o  out  1  sticky: resolution arrived with empty queue.

Function
REQ-018 Queue SHALL store {predict_i, alt_pc_i} per branch in FIFO order; count range 0..DEPTH.
REQ-019 Enqueue SHALL occur when br_valid_i=1, queue not full, state NORMAL, and no mispredict detected this cycle.
REQ-020 stall_o SHALL equal (count==DEPTH) & br_valid_i, combinational; an enqueue while full SHALL be ignored.
REQ-021 Resolution SHALL pop the head when res_valid_i=1 and queue non-empty; mispredict = head.predict != res_taken_i.
REQ-022 Simultaneous enqueue and non-mispredicting pop SHALL leave count unchanged, including when full.
REQ-023 update_o SHALL pulse exactly one cycle after every valid pop, with result_o = registered res_taken_i; otherwise update_o=0.
REQ-024 FSM states NORMAL, RECOVER; NORMAL->RECOVER on mispredict; RECOVER->NORMAL after RECOVER_CYCLES cycles.
REQ-025 On mispredict, the entire queue SHALL be cleared (all entries younger), count=0 next cycle.
REQ-026 flush_o SHALL be 1 for exactly RECOVER_CYCLES cycles starting the cycle after the mispredict; redirect_pc_o = head.alt_pc latched at detection, held stable throughout.
REQ-027 In RECOVER, br_valid_i SHALL be ignored and stall_o SHALL be 0; res_valid_i with empty queue SHALL NOT set err_o.
REQ-028 In NORMAL, res_valid_i with empty queue SHALL set err_o (sticky until reset) and produce no update_o.
REQ-029 mispred_cnt_o SHALL increment by 1 per mispredict, saturating at 16'hFFFF.
REQ-030 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-031 rst_i=0 SHALL asynchronously force: state NORMAL, count 0, pointers 0, update_o 0, result_o 0, flush_o 0, redirect_pc_o 0, mispred_cnt_o 0, err_o 0.
REQ-032 Reset asserted during RECOVER SHALL terminate flush_o immediately; first enqueue permitted the first edge after release.

Structure
REQ-033 Package bp_pkg SHALL hold the FSM state enum and the queue entry struct {pred, alt_pc}.
REQ-034 Queue SHALL be a sub-module branch_fifo (parameterised DEPTH, data width, push/pop/clear, full/empty/count).
REQ-035 Controller logic (FSM, flush timer, counters) SHALL reside in branch_resolve_ctrl only.

Verification
REQ-036 Enqueue pred=1 alt=0x100, resolve taken -> next cycle update_o=1, result_o=1, flush_o=0, mispred_cnt_o=0.
REQ-037 Enqueue pred=1 alt=0x204, resolve not-taken -> next cycle flush_o=1 one cycle, redirect_pc_o=0x204, update_o=1 result_o=0, count=0, mispred_cnt_o=1.
REQ-038 Fill 4 entries, br_valid_i=1 -> stall_o=1; same cycle res_valid_i correct -> pop+push, count stays 4.
REQ-039 RECOVER_CYCLES=3, mispredict with 3 entries queued -> flush_o high 3 cycles, br_valid_i ignored, then NORMAL accepts enqueue.
REQ-040 res_valid_i with empty queue in NORMAL -> err_o=1 sticky, no update_o; rst_i=0 clears it.
REQ-041 Assert rst_i mid-flush -> flush_o, count, mispred_cnt_o to 0 without waiting for clock edge.
